// File: rtl/eth_frame_tx.sv
// Ethernet frame serializer: preamble/SFD, MAC headers, payload with zero pad,
// reflected CRC-32 FCS and inter-frame gap; one bit per BIT_DIV clocks, LSB first.
module eth_frame_tx #(
  parameter int BIT_DIV  = 2,
  parameter int IFG_BITS = 96
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [47:0] dst_mac,
  input  logic [47:0] src_mac,
  input  logic [15:0] eth_type,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  input  logic        pl_last,
  output logic        pl_ready,
  output logic        tx_bit,
  output logic        tx_active,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int IFG_CYC = IFG_BITS * BIT_DIV;
  localparam int GW = (IFG_CYC > 1) ? $clog2(IFG_CYC) : 1;
  localparam logic [31:0] POLY = 32'hEDB88320;
  localparam logic [10:0] MIN_PAY = 11'd46;
  localparam logic [10:0] MAX_PAY = 11'd1500;

  typedef enum logic [3:0] {
    IDLE, PREAMBLE, SFD, DST, SRC, TYPE, PAYLOAD, PAD, FCS, IFG
  } state_t;

  state_t        state_q;
  logic [DW-1:0] div_q;
  logic [4:0]    bit_q;
  logic [2:0]    byte_q;
  logic [10:0]   pay_q;
  logic [GW-1:0] gap_q;
  logic [31:0]   sh_q;
  logic [31:0]   crc_q;
  logic [31:0]   crc_d;
  logic [111:0]  hdr_q;
  logic [7:0]    holdData_q;
  logic          holdValid_q;
  logic          holdLast_q;
  logic          lastAcc_q;
  logic          curLast_q;
  logic          bitEnd;
  logic          lastBit;
  logic          wantPay;
  logic          crcEn;

  always_comb begin
    crc_d   = {1'b0, crc_q[31:1]} ^ ((crc_q[0] ^ tx_bit) ? POLY : 32'h0);
    bitEnd  = (div_q == DW'(BIT_DIV - 1));
    lastBit = (state_q == FCS) ? (bit_q == 5'd31) : (bit_q == 5'd7);
    wantPay = (state_q == TYPE && byte_q == 3'd1) ||
              (state_q == PAYLOAD && !curLast_q && pay_q != MAX_PAY);
    crcEn   = state_q inside {DST, SRC, TYPE, PAYLOAD, PAD};
  end

  assign pl_ready = !holdValid_q && !lastAcc_q && (state_q == TYPE || state_q == PAYLOAD);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      byte_q      <= '0;
      pay_q       <= '0;
      gap_q       <= '0;
      sh_q        <= '0;
      crc_q       <= '1;
      hdr_q       <= '0;
      holdData_q  <= '0;
      holdValid_q <= 1'b0;
      holdLast_q  <= 1'b0;
      lastAcc_q   <= 1'b0;
      curLast_q   <= 1'b0;
      tx_bit      <= 1'b0;
      tx_active   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (pl_valid && pl_ready) begin
        holdData_q  <= pl_data;
        holdLast_q  <= pl_last;
        holdValid_q <= 1'b1;
        lastAcc_q   <= pl_last;
      end
      if (bitEnd && crcEn) crc_q <= crc_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= PREAMBLE;
            hdr_q       <= {dst_mac, src_mac, eth_type};
            crc_q       <= '1;
            sh_q        <= 32'h55;
            tx_bit      <= 1'b1;
            tx_active   <= 1'b1;
            busy        <= 1'b1;
            div_q       <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            pay_q       <= '0;
            holdValid_q <= 1'b0;
            lastAcc_q   <= 1'b0;
            curLast_q   <= 1'b0;
          end
        end
        IFG: begin
          if (gap_q == GW'(IFG_CYC - 1)) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: begin
          div_q <= bitEnd ? '0 : div_q + DW'(1);
          if (bitEnd && !lastBit) begin
            bit_q  <= bit_q + 5'd1;
            sh_q   <= sh_q >> 1;
            tx_bit <= sh_q[1];
          end else if (bitEnd) begin
            bit_q <= '0;
            if (state_q == FCS) begin
              state_q   <= IFG;
              gap_q     <= '0;
              tx_active <= 1'b0;
              tx_bit    <= 1'b0;
              done      <= 1'b1;
            end else if (wantPay && holdValid_q) begin
              state_q     <= PAYLOAD;
              sh_q        <= {24'h0, holdData_q};
              tx_bit      <= holdData_q[0];
              holdValid_q <= 1'b0;
              curLast_q   <= holdLast_q;
              pay_q       <= pay_q + 11'd1;
            end else if (wantPay || (state_q == PAYLOAD && !curLast_q)) begin
              // Underrun or oversize: drop the frame without an FCS.
              state_q     <= IFG;
              gap_q       <= '0;
              tx_active   <= 1'b0;
              tx_bit      <= 1'b0;
              err         <= 1'b1;
              holdValid_q <= 1'b0;
            end else if ((state_q == PAYLOAD || state_q == PAD) && pay_q >= MIN_PAY) begin
              state_q <= FCS;
              sh_q    <= ~crc_d;
              tx_bit  <= ~crc_d[0];
            end else if (state_q == PAYLOAD || state_q == PAD) begin
              state_q <= PAD;
              sh_q    <= '0;
              tx_bit  <= 1'b0;
              pay_q   <= pay_q + 11'd1;
            end else begin
              case (state_q)
                PREAMBLE: begin
                  byte_q <= (byte_q == 3'd6) ? 3'd0 : byte_q + 3'd1;
                  sh_q   <= (byte_q == 3'd6) ? 32'hD5 : 32'h55;
                  tx_bit <= 1'b1;
                  if (byte_q == 3'd6) state_q <= SFD;
                end
                default: begin
                  // Header bytes come off the top of the captured dst/src/type word.
                  sh_q   <= {24'h0, hdr_q[111:104]};
                  tx_bit <= hdr_q[104];
                  hdr_q  <= hdr_q << 8;
                  byte_q <= byte_q + 3'd1;
                  if (state_q == SFD) begin
                    state_q <= DST;
                    byte_q  <= '0;
                  end else if (state_q == DST && byte_q == 3'd5) begin
                    state_q <= SRC;
                    byte_q  <= '0;
                  end else if (state_q == SRC && byte_q == 3'd5) begin
                    state_q <= TYPE;
                    byte_q  <= '0;
                  end
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_tx.sv
// Self-checking bench for eth_frame_tx: frames are captured bit by bit and
// compared with a byte-level frame model (headers, payload, pad, CRC-32 FCS).
module tb_eth_frame_tx;
  localparam int BIT_DIV  = 2;
  localparam int IFG_BITS = 96;
  localparam int IFG_CYC  = IFG_BITS * BIT_DIV;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic [15:0] eth_type;
  logic [7:0]  pl_data;
  logic        pl_valid;
  logic        pl_last;
  logic        pl_ready;
  logic        tx_bit;
  logic        tx_active;
  logic        busy;
  logic        done;
  logic        err;

  eth_frame_tx #(.BIT_DIV(BIT_DIV), .IFG_BITS(IFG_BITS)) dut (
    .CLK(CLK), .RST(RST), .start(start), .dst_mac(dst_mac), .src_mac(src_mac),
    .eth_type(eth_type), .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last),
    .pl_ready(pl_ready), .tx_bit(tx_bit), .tx_active(tx_active), .busy(busy),
    .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  int testCnt = 0;
  int failCnt = 0;

  bit capQ[$];
  int doneCnt = 0;
  int errCnt = 0;
  int doneCyc = -1;
  int errCyc = -1;
  int busyFallCyc = -1;
  int cyc = 0;
  int idleBitViol = 0;
  int readyAfterErr = 0;
  int clearGen = 0;
  int seenGen = 0;
  bit busyPrev = 1'b0;
  bit errWin = 1'b0;

  bit expBits[$];
  bit [7:0] pl[$];
  bit [31:0] modelCrc;
  bit frameOver;

  // Line monitor, sampled on the falling edge; per-frame state is cleared when clearGen moves.
  always @(negedge CLK) begin
    if (seenGen != clearGen) begin
      seenGen = clearGen;
      capQ.delete();
      doneCnt = 0;
      errCnt = 0;
      doneCyc = -1;
      errCyc = -1;
      busyFallCyc = -1;
    end
    cyc++;
    if (tx_active) capQ.push_back(tx_bit);
    if (!tx_active && tx_bit) idleBitViol++;
    if (done) begin doneCnt++; doneCyc = cyc; end
    if (err) begin errCnt++; errCyc = cyc; errWin = 1'b1; end
    if (errWin && pl_ready) readyAfterErr++;
    if (busyPrev && !busy) begin busyFallCyc = cyc; errWin = 1'b0; end
    busyPrev = busy;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] crcStep(input bit [31:0] c, input bit b);
    return (c >> 1) ^ ((c[0] ^ b) ? 32'hEDB88320 : 32'h0);
  endfunction

  task automatic pushByte(input bit [7:0] b, input bit inCrc);
    for (int k = 0; k < 8; k++) begin
      expBits.push_back(b[k]);
      if (inCrc) modelCrc = crcStep(modelCrc, b[k]);
    end
  endtask

  task automatic buildExpected(input int sent, input bit complete);
    bit [31:0] fcs;
    expBits.delete();
    modelCrc = '1;
    for (int i = 0; i < 7; i++) pushByte(8'h55, 1'b0);
    pushByte(8'hD5, 1'b0);
    for (int i = 5; i >= 0; i--) pushByte(dst_mac[8*i +: 8], 1'b1);
    for (int i = 5; i >= 0; i--) pushByte(src_mac[8*i +: 8], 1'b1);
    pushByte(eth_type[15:8], 1'b1);
    pushByte(eth_type[7:0], 1'b1);
    for (int i = 0; i < sent; i++) pushByte(pl[i], 1'b1);
    if (complete) begin
      for (int i = sent; i < 46; i++) pushByte(8'h00, 1'b1);
      fcs = ~modelCrc;
      for (int k = 0; k < 32; k++) expBits.push_back(fcs[k]);
    end
  endtask

  task automatic randomHeaders();
    dst_mac  = {16'($urandom), 32'($urandom)};
    src_mac  = {16'($urandom), 32'($urandom)};
    eth_type = 16'($urandom);
  endtask

  task automatic randomPayload(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
  endtask

  task automatic runFrame(input string tag, input int n, input int stallAfter,
                          input bit withLast, input bit pokeStart);
    int sent;
    bit complete;
    int budget;
    bit timedOut;
    int nBits;
    int mism;
    int endCyc;
    if (stallAfter > 0) begin sent = stallAfter; complete = 1'b0; end
    else if (n > 1500) begin sent = 1500; complete = 1'b0; end
    else begin sent = n; complete = 1'b1; end
    buildExpected(sent, complete);
    frameOver = 1'b0;
    timedOut = 1'b0;
    clearGen++;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check({tag, "_accept"}, {61'd0, busy, tx_active, tx_bit}, 64'd7);
    fork
      begin
        for (int i = 0; i < n && !frameOver; i++) begin
          pl_data  = pl[i];
          pl_last  = withLast && (i == n - 1);
          pl_valid = 1'b1;
          while (!pl_ready && !frameOver) @(negedge CLK);
          if (!frameOver) @(negedge CLK);
          if (i + 1 == stallAfter) begin
            pl_valid = 1'b0;
            pl_last  = 1'b0;
            repeat (40) @(negedge CLK);
          end
        end
        pl_valid = 1'b0;
        pl_last  = 1'b0;
      end
      begin
        budget = 0;
        while (!(done || err) && budget < (n + 40) * 8 * BIT_DIV + 2000) begin
          @(negedge CLK);
          budget++;
        end
        if (!(done || err)) timedOut = 1'b1;
        if (pokeStart) begin
          repeat (20) @(negedge CLK);
          start = 1'b1;
          @(negedge CLK);
          start = 1'b0;
        end
        budget = 0;
        while (busy && budget < 4 * IFG_CYC) begin
          @(negedge CLK);
          budget++;
        end
        if (busy) timedOut = 1'b1;
        @(negedge CLK);
        frameOver = 1'b1;
      end
      begin
        if (pokeStart) begin
          repeat (30 * 8 * BIT_DIV) @(negedge CLK);
          start = 1'b1;
          @(negedge CLK);
          start = 1'b0;
        end
      end
    join
    check({tag, "_timeout"}, 64'(timedOut), 64'd0);
    nBits = expBits.size();
    check({tag, "_active_cycles"}, 64'(capQ.size()), 64'(nBits * BIT_DIV));
    mism = 0;
    for (int i = 0; i < capQ.size(); i++)
      if (i / BIT_DIV < nBits && capQ[i] != expBits[i / BIT_DIV]) mism++;
    check({tag, "_bit_errors"}, 64'(mism), 64'd0);
    check({tag, "_done"}, 64'(doneCnt), complete ? 64'd1 : 64'd0);
    check({tag, "_err"}, 64'(errCnt), complete ? 64'd0 : 64'd1);
    endCyc = complete ? doneCyc : errCyc;
    check({tag, "_ifg"}, 64'(busyFallCyc - endCyc), 64'(IFG_CYC));
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, observed %0d expected %0d", cyc, 0);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] first;
    bit [31:0] rx;
    int n;
    int activeSeen;

    RST = 1'b1; start = 1'b0; dst_mac = '0; src_mac = '0; eth_type = '0;
    pl_data = '0; pl_valid = 1'b0; pl_last = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_outputs", {58'd0, tx_bit, tx_active, busy, done, err, pl_ready}, 64'd0);
    RST = 1'b0;
    @(negedge CLK);
    check("idle_outputs", {58'd0, tx_bit, tx_active, busy, done, err, pl_ready}, 64'd0);

    // Minimum-size frame: 46 zero bytes, broadcast destination.
    dst_mac = 48'hFFFF_FFFF_FFFF; src_mac = '0; eth_type = 16'h002E;
    pl.delete();
    for (int i = 0; i < 46; i++) pl.push_back(8'h00);
    runFrame("min46", 46, 0, 1'b1, 1'b0);
    first = '0;
    for (int i = 0; i < 64; i++)
      if (i * BIT_DIV < capQ.size()) first = {first[62:0], capQ[i * BIT_DIV]};
    check("preamble_sfd", first, 64'hAAAA_AAAA_AAAA_AAAB);

    // Short payload padded up to 46 bytes; receiver-side CRC must leave the magic residue.
    pl.delete();
    for (int i = 1; i <= 10; i++) pl.push_back(8'(i));
    runFrame("pad10", 10, 0, 1'b1, 1'b0);
    rx = '1;
    for (int i = 64; i < capQ.size() / BIT_DIV; i++) rx = crcStep(rx, capQ[i * BIT_DIV]);
    check("crc_residue", 64'(rx), 64'hDEBB20E3);

    for (int f = 0; f < 3; f++) begin
      randomHeaders();
      n = $urandom_range(1, 120);
      randomPayload(n);
      runFrame($sformatf("rand%0d", f), n, 0, 1'b1, 1'b0);
    end

    // start pulses mid-payload and during the gap must not launch another frame.
    randomHeaders();
    randomPayload(60);
    runFrame("poke", 60, 0, 1'b1, 1'b1);
    activeSeen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (tx_active || busy) activeSeen++;
    end
    check("poke_single_frame", 64'(activeSeen), 64'd0);

    randomHeaders();
    randomPayload(100);
    runFrame("underrun", 100, 20, 1'b1, 1'b0);
    check("underrun_ready_low", 64'(readyAfterErr), 64'd0);

    // Reset while the source address is on the wire, then restart straight away.
    randomHeaders();
    n = $urandom_range(20, 80);
    randomPayload(n);
    clearGen++;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (2 * 130) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("reset_mid_src", {58'd0, tx_bit, tx_active, busy, done, err, pl_ready}, 64'd0);
    check("reset_no_pulse", 64'(doneCnt + errCnt), 64'd0);
    RST = 1'b0;
    runFrame("after_reset", n, 0, 1'b1, 1'b0);

    randomHeaders();
    randomPayload(1501);
    runFrame("oversize", 1501, 0, 1'b1, 1'b0);
    check("oversize_ready_low", 64'(readyAfterErr), 64'd0);
    check("idle_bit_zero", 64'(idleBitViol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
